sw_debounce_sync: RTL and testbench

Input-side companion to the LED output path: samples the 16 board slide switches and turns them into clean, debounced levels plus single-cycle edge strobes. Consumers such as marquee, pattern and mode logic use these instead of raw SW. Contents: a two-flop synchronizer, per-bit debounce counters, and registered rise/fall/change pulses. Sits between the top-level SW pins and all switch-driven control logic.

---
 rtl/sw_debounce_sync.sv | 100 ++++++++++
 tb/tb_sw_debounce_sync.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_sync.sv
// Two-flop synchronizer plus per-bit debounce for the 16 slide switches, with registered rise/fall/change strobes.
// Optional change latch (chg_ack/chg_pending/chg_mask) is built when SW_CHANGE_LATCH_EN is defined.
module sw_debounce_sync #(
   parameter  int DEBOUNCE_CNT = 1_000_000,
   localparam int CNT_W        = $clog2(DEBOUNCE_CNT + 1)
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic [15:0] SW,
`ifdef SW_CHANGE_LATCH_EN
   input  logic        chg_ack,
   output logic        chg_pending,
   output logic [15:0] chg_mask,
`endif
   output logic [15:0] sw_stable,
   output logic [15:0] sw_rise,
   output logic [15:0] sw_fall,
   output logic        sw_changed
);

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   logic [15:0]      r_sync1;
   logic [15:0]      r_sync2;
   logic [15:0]      r_stable;
   logic [15:0]      r_rise;
   logic [15:0]      r_fall;
   logic             r_changed;
   logic [CNT_W-1:0] r_cnt     [16];

   logic [CNT_W-1:0] w_cnt_nxt [16];
   logic [15:0]      w_flip;

   // A bit flips only after DEBOUNCE_CNT consecutive mismatching cycles; any match restarts the count.
   always_comb begin
      w_flip = '0;
      for (int i = 0; i < 16; i++) begin
         w_cnt_nxt[i] = '0;
         if (r_sync2[i] != r_stable[i]) begin
            if (r_cnt[i] == C_LAST) begin
               w_flip[i] = 1'b1;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_sync1   <= '0;
         r_sync2   <= '0;
         r_stable  <= '0;
         r_rise    <= '0;
         r_fall    <= '0;
         r_changed <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1   <= SW;
         r_sync2   <= r_sync1;
         r_stable  <= r_stable ^ w_flip;
         r_rise    <= w_flip & ~r_stable;
         r_fall    <= w_flip & r_stable;
         r_changed <= |w_flip;
         for (int i = 0; i < 16; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
      end
   end

   assign sw_stable  = r_stable;
   assign sw_rise    = r_rise;
   assign sw_fall    = r_fall;
   assign sw_changed = r_changed;

`ifdef SW_CHANGE_LATCH_EN
   logic [15:0] r_chg_mask;
   logic        r_chg_pending;

   // An edge arriving with the ack survives it: the mask restarts from the new edge bits.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         r_chg_mask    <= '0;
         r_chg_pending <= 1'b0;
      end else if (chg_ack) begin
         r_chg_mask    <= w_flip;
         r_chg_pending <= |w_flip;
      end else begin
         r_chg_mask    <= r_chg_mask | w_flip;
         r_chg_pending <= |(r_chg_mask | w_flip);
      end
   end

   assign chg_mask    = r_chg_mask;
   assign chg_pending = r_chg_pending;
`endif

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Directed bench for sw_debounce_sync with DEBOUNCE_CNT=4; inputs change and outputs are checked on falling edges.
module tb_sw_debounce_sync;

   logic        clk;
   logic        rst_n;
   logic [15:0] sw;
   logic [15:0] sw_stable;
   logic [15:0] sw_rise;
   logic [15:0] sw_fall;
   logic        sw_changed;
`ifdef SW_CHANGE_LATCH_EN
   logic        chg_ack;
   logic        chg_pending;
   logic [15:0] chg_mask;
`endif

   int n_cmp = 0;
   int n_err = 0;

   sw_debounce_sync #(.DEBOUNCE_CNT(4)) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rst_n),
      .SW         (sw),
`ifdef SW_CHANGE_LATCH_EN
      .chg_ack    (chg_ack),
      .chg_pending(chg_pending),
      .chg_mask   (chg_mask),
`endif
      .sw_stable  (sw_stable),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .sw_changed (sw_changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_all(input string tag, input logic [15:0] st, input logic [15:0] ri,
                          input logic [15:0] fa, input logic ch);
      chk({tag, ".stable"},  sw_stable, st);
      chk({tag, ".rise"},    sw_rise, ri);
      chk({tag, ".fall"},    sw_fall, fa);
      chk({tag, ".changed"}, {15'b0, sw_changed}, {15'b0, ch});
   endtask

   initial begin
      rst_n = 1'b0;
      sw    = 16'hFFFF;
`ifdef SW_CHANGE_LATCH_EN
      chg_ack = 1'b0;
`endif
      // Reset with all switches high, then release; flip shows 6 falling edges later
      nclk(10);
      chk_all("rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
      rst_n = 1'b1;
      nclk(5);
      chk_all("t1_n5", 16'h0000, 16'h0000, 16'h0000, 1'b0);
      nclk(1);
      chk_all("t1_n6", 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1);
      nclk(1);
      chk_all("t1_n7", 16'hFFFF, 16'h0000, 16'h0000, 1'b0);

      // All switches low again
      sw = 16'h0000;
      nclk(5);
      chk("t1b_n5.stable", sw_stable, 16'hFFFF);
      nclk(1);
      chk_all("t1b_n6", 16'h0000, 16'h0000, 16'hFFFF, 1'b1);
      nclk(1);
      chk_all("t1b_n7", 16'h0000, 16'h0000, 16'h0000, 1'b0);

      // Single bit rise
      sw = 16'h0001;
      nclk(5);
      chk_all("t2_n5", 16'h0000, 16'h0000, 16'h0000, 1'b0);
      nclk(1);
      chk_all("t2_n6", 16'h0001, 16'h0001, 16'h0000, 1'b1);
      nclk(1);
      chk_all("t2_n7", 16'h0001, 16'h0000, 16'h0000, 1'b0);

      // 3-cycle glitch on bit 3 is rejected
      sw = 16'h0009;
      nclk(3);
      sw = 16'h0001;
      for (int i = 0; i < 8; i++) begin
         nclk(1);
         chk_all($sformatf("t3g_%0d", i), 16'h0001, 16'h0000, 16'h0000, 1'b0);
      end

      // 4-cycle pulse on bit 3 is accepted, then falls again
      sw = 16'h0009;
      nclk(4);
      sw = 16'h0001;
      nclk(1);
      chk_all("t3p_n5", 16'h0001, 16'h0000, 16'h0000, 1'b0);
      nclk(1);
      chk_all("t3p_n6", 16'h0009, 16'h0008, 16'h0000, 1'b1);
      nclk(3);
      chk_all("t3p_n9", 16'h0009, 16'h0000, 16'h0000, 1'b0);
      nclk(1);
      chk_all("t3p_n10", 16'h0001, 16'h0000, 16'h0008, 1'b1);
      nclk(1);

      // Two bits together
      sw = 16'h8003;
      nclk(5);
      chk_all("t4r_n5", 16'h0001, 16'h0000, 16'h0000, 1'b0);
      nclk(1);
      chk_all("t4r_n6", 16'h8003, 16'h8002, 16'h0000, 1'b1);
      nclk(1);
      chk_all("t4r_n7", 16'h8003, 16'h0000, 16'h0000, 1'b0);
      sw = 16'h0001;
      nclk(5);
      chk_all("t4f_n5", 16'h8003, 16'h0000, 16'h0000, 1'b0);
      nclk(1);
      chk_all("t4f_n6", 16'h0001, 16'h0000, 16'h8002, 1'b1);
      nclk(1);
      chk_all("t4f_n7", 16'h0001, 16'h0000, 16'h0000, 1'b0);

      // Reset during debounce of bit 5
      sw = 16'h0021;
      nclk(2);
      chk_all("t5_pre", 16'h0001, 16'h0000, 16'h0000, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_all("t5_async", 16'h0000, 16'h0000, 16'h0000, 1'b0);
      nclk(5);
      chk_all("t5_hold", 16'h0000, 16'h0000, 16'h0000, 1'b0);
      rst_n = 1'b1;
      nclk(5);
      chk_all("t5_n5", 16'h0000, 16'h0000, 16'h0000, 1'b0);
      nclk(1);
      chk_all("t5_n6", 16'h0021, 16'h0021, 16'h0000, 1'b1);
      nclk(1);
      chk_all("t5_n7", 16'h0021, 16'h0000, 16'h0000, 1'b0);

`ifdef SW_CHANGE_LATCH_EN
      chk("t6_init.mask", chg_mask, 16'h0021);
      chk("t6_init.pend", {15'b0, chg_pending}, 16'h0001);
      chg_ack = 1'b1;
      nclk(1);
      chg_ack = 1'b0;
      chk("t6_clr0.mask", chg_mask, 16'h0000);
      chk("t6_clr0.pend", {15'b0, chg_pending}, 16'h0000);
      sw = 16'h0025;
      nclk(6);
      chk("t6_a.mask", chg_mask, 16'h0004);
      chk("t6_a.pend", {15'b0, chg_pending}, 16'h0001);
      nclk(1);
      sw = 16'h00A5;
      nclk(6);
      chk("t6_b.mask", chg_mask, 16'h0084);
      chk("t6_b.pend", {15'b0, chg_pending}, 16'h0001);
      nclk(1);
      chk("t6_b1.mask", chg_mask, 16'h0084);
      chg_ack = 1'b1;
      nclk(1);
      chg_ack = 1'b0;
      chk("t6_ack.mask", chg_mask, 16'h0000);
      chk("t6_ack.pend", {15'b0, chg_pending}, 16'h0000);
      chg_ack = 1'b1;
      nclk(1);
      chg_ack = 1'b0;
      chk("t6_idleack.mask", chg_mask, 16'h0000);
      chk("t6_idleack.pend", {15'b0, chg_pending}, 16'h0000);
      sw = 16'h02A5;
      nclk(5);
      chg_ack = 1'b1;
      nclk(1);
      chg_ack = 1'b0;
      chk("t6_race.stable", sw_stable, 16'h02A5);
      chk("t6_race.mask", chg_mask, 16'h0200);
      chk("t6_race.pend", {15'b0, chg_pending}, 16'h0001);
      nclk(2);
      chk("t6_hold.mask", chg_mask, 16'h0200);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
